// File: rtl/shot_sequencer.sv
// Turn controller in front of the battleship scorer: conditions the fire key,
// latches each shot, strobes the scorer, and tallies shots, big shots and hits.
module shot_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_SHOTS       = 20,
  parameter int BIG_SHOTS       = 3,
  parameter int HITS_TO_WIN     = 17
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       FireKey,
  input  logic [3:0] XIn,
  input  logic [3:0] YIn,
  input  logic       BigReq,
  input  logic       Hit,
  input  logic       NearMiss,
  input  logic       Miss,
  input  logic       SomethingIsWrong,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic       Big,
  output logic [1:0] BigLeft,
  output logic       ScoreThis,
  output logic [4:0] ShotsLeft,
  output logic [4:0] HitCount,
  output logic [1:0] LastResult,
  output logic       GameOver,
  output logic       Won
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]    SHOTS_INIT = 5'(MAX_SHOTS);
  localparam logic [4:0]    HITS_WIN   = 5'(HITS_TO_WIN);
  localparam logic [1:0]    BIG_INIT   = 2'(BIG_SHOTS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    FIRE   = 3'd2,
    RESULT = 3'd3,
    DONE   = 3'd4
  } state_t;

  logic          sync1_r, sync2_r;
  logic [CW-1:0] db_cnt_r;
  logic          db_level_r, db_prev_r;
  logic          fire_s;

  state_t     state_r, state_s;
  logic [3:0] x_r, x_s, y_r, y_s;
  logic       big_r, big_s, score_r, score_s, over_r, over_s, won_r, won_s;
  logic [1:0] bl_r, bl_s, last_r, last_s;
  logic [4:0] shots_r, shots_s, hits_r, hits_s;

  // Synchronizer, debouncer and edge-detect history for the fire key.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      db_cnt_r   <= '0;
      db_level_r <= 1'b0;
      db_prev_r  <= 1'b0;
    end else begin
      sync1_r   <= FireKey;
      sync2_r   <= sync1_r;
      db_prev_r <= db_level_r;
      if (sync2_r == db_level_r) begin
        db_cnt_r <= '0;
      end else if (db_cnt_r == DB_LAST) begin
        db_level_r <= sync2_r;
        db_cnt_r   <= '0;
      end else begin
        db_cnt_r <= db_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign fire_s = db_level_r & ~db_prev_r;

  // State and output registers; every output is a flop so the scorer sees clean levels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      x_r     <= 4'd0;
      y_r     <= 4'd0;
      big_r   <= 1'b0;
      score_r <= 1'b0;
      bl_r    <= BIG_INIT;
      shots_r <= SHOTS_INIT;
      hits_r  <= 5'd0;
      last_r  <= 2'b00;
      over_r  <= 1'b0;
      won_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      x_r     <= x_s;
      y_r     <= y_s;
      big_r   <= big_s;
      score_r <= score_s;
      bl_r    <= bl_s;
      shots_r <= shots_s;
      hits_r  <= hits_s;
      last_r  <= last_s;
      over_r  <= over_s;
      won_r   <= won_s;
    end
  end

  // Next-state and next-output logic; a Fire edge outside IDLE is simply dropped.
  always_comb begin
    state_s = state_r;
    x_s     = x_r;
    y_s     = y_r;
    big_s   = big_r;
    score_s = 1'b0;
    bl_s    = bl_r;
    shots_s = shots_r;
    hits_s  = hits_r;
    last_s  = last_r;
    over_s  = over_r;
    won_s   = won_r;
    case (state_r)
      IDLE: begin
        if (fire_s) state_s = ARM;
        else        state_s = IDLE;
      end
      ARM: begin
        x_s     = XIn;
        y_s     = YIn;
        big_s   = BigReq & (bl_r != 2'd0);
        score_s = 1'b1;
        state_s = FIRE;
      end
      FIRE: begin
        state_s = RESULT;
      end
      RESULT: begin
        if (SomethingIsWrong) begin
          last_s  = 2'b00;
          state_s = IDLE;
        end else begin
          shots_s = (shots_r != 5'd0) ? shots_r - 5'd1 : 5'd0;
          if (big_r && (bl_r != 2'd0)) bl_s = bl_r - 2'd1;
          else                         bl_s = bl_r;
          if (Hit) begin
            last_s = 2'b11;
            hits_s = (hits_r < HITS_WIN) ? hits_r + 5'd1 : hits_r;
          end else if (NearMiss) begin
            last_s = 2'b10;
          end else if (Miss) begin
            last_s = 2'b01;
          end else begin
            last_s = 2'b00;
          end
          // A win takes precedence when the last shot also empties the budget.
          if (hits_s == HITS_WIN) begin
            over_s  = 1'b1;
            won_s   = 1'b1;
            state_s = DONE;
          end else if (shots_s == 5'd0) begin
            over_s  = 1'b1;
            won_s   = 1'b0;
            state_s = DONE;
          end else begin
            state_s = IDLE;
          end
        end
      end
      DONE: begin
        state_s = DONE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign X          = x_r;
  assign Y          = y_r;
  assign Big        = big_r;
  assign BigLeft    = bl_r;
  assign ScoreThis  = score_r;
  assign ShotsLeft  = shots_r;
  assign HitCount   = hits_r;
  assign LastResult = last_r;
  assign GameOver   = over_r;
  assign Won        = won_r;

endmodule

// File: tb/tb_shot_sequencer.sv
// Scoreboard bench for shot_sequencer: each press queues the expected shot, a
// monitor checks latched coordinates on every ScoreThis and the tallies afterwards.
module tb_shot_sequencer;

  logic       clock = 1'b0;
  logic       reset, FireKey, BigReq, Hit, NearMiss, Miss, SomethingIsWrong;
  logic [3:0] XIn, YIn, X, Y;
  logic       Big, ScoreThis, GameOver, Won;
  logic [1:0] BigLeft, LastResult;
  logic [4:0] ShotsLeft, HitCount;

  always #5 clock = ~clock;

  shot_sequencer #(
    .DEBOUNCE_CYCLES(4), .MAX_SHOTS(5), .BIG_SHOTS(3), .HITS_TO_WIN(3)
  ) dut (
    .clock(clock), .reset(reset), .FireKey(FireKey), .XIn(XIn), .YIn(YIn),
    .BigReq(BigReq), .Hit(Hit), .NearMiss(NearMiss), .Miss(Miss),
    .SomethingIsWrong(SomethingIsWrong), .X(X), .Y(Y), .Big(Big),
    .BigLeft(BigLeft), .ScoreThis(ScoreThis), .ShotsLeft(ShotsLeft),
    .HitCount(HitCount), .LastResult(LastResult), .GameOver(GameOver), .Won(Won)
  );

  typedef struct {
    int x, y, big, shots, bl, hits, last, over, won;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest queued shot.
  always begin
    exp_t e;
    @(negedge clock);
    if (ScoreThis === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("x", int'(X), e.x);
        chk("y", int'(Y), e.y);
        chk("big", int'(Big), e.big);
        @(negedge clock);
        chk("strobe_width", int'(ScoreThis), 0);
        @(negedge clock);
        chk("shots_left", int'(ShotsLeft), e.shots);
        chk("big_left", int'(BigLeft), e.bl);
        chk("hit_count", int'(HitCount), e.hits);
        chk("last_result", int'(LastResult), e.last);
        chk("game_over", int'(GameOver), e.over);
        chk("won", int'(Won), e.won);
      end
    end
  end

  // res: 0 none, 1 miss, 2 near, 3 hit, 4 rejected
  task automatic shot(input int x, input int y, input int bigreq, input int res,
                      input int ebig, input int eshots, input int ebl, input int ehits,
                      input int elast, input int eover, input int ewon, input bit strobe);
    exp_t e;
    e = '{x: x, y: y, big: ebig, shots: eshots, bl: ebl, hits: ehits,
          last: elast, over: eover, won: ewon};
    if (strobe) sb.push_back(e);
    XIn = 4'(x);
    YIn = 4'(y);
    BigReq = (bigreq != 0);
    Hit = (res == 3);
    NearMiss = (res == 2);
    Miss = (res == 1);
    SomethingIsWrong = (res == 4);
    FireKey = 1'b1;
    repeat (8) @(negedge clock);
    XIn = ~XIn;
    YIn = ~YIn;
    BigReq = ~BigReq;
    repeat (2) @(negedge clock);
    FireKey = 1'b0;
    repeat (12) @(negedge clock);
    Hit = 1'b0;
    NearMiss = 1'b0;
    Miss = 1'b0;
    SomethingIsWrong = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int seen;
    reset = 1'b1; FireKey = 1'b0; XIn = 4'd0; YIn = 4'd0; BigReq = 1'b0;
    Hit = 1'b0; NearMiss = 1'b0; Miss = 1'b0; SomethingIsWrong = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_x", int'(X), 0);
    chk("rst_y", int'(Y), 0);
    chk("rst_big", int'(Big), 0);
    chk("rst_strobe", int'(ScoreThis), 0);
    chk("rst_last", int'(LastResult), 0);
    chk("rst_hits", int'(HitCount), 0);
    chk("rst_over", int'(GameOver), 0);
    chk("rst_won", int'(Won), 0);
    chk("rst_big_left", int'(BigLeft), 3);
    chk("rst_shots_left", int'(ShotsLeft), 5);

    // Glitch shorter than the debounce window: no strobe may follow.
    FireKey = 1'b1;
    repeat (3) @(negedge clock);
    FireKey = 1'b0;
    repeat (12) @(negedge clock);

    shot(1, 2, 0, 1,   0, 4, 3, 0, 1, 0, 0, 1'b1);
    shot(4, 5, 0, 2,   0, 3, 3, 0, 2, 0, 0, 1'b1);
    shot(3, 7, 0, 3,   0, 2, 3, 1, 3, 0, 0, 1'b1);
    shot(15, 15, 1, 4, 1, 2, 3, 1, 0, 0, 0, 1'b1);

    // Big-shot budget, then running out of shots.
    do_reset();
    shot(1, 1, 1, 1,   1, 4, 2, 0, 1, 0, 0, 1'b1);
    shot(2, 2, 1, 1,   1, 3, 1, 0, 1, 0, 0, 1'b1);
    shot(3, 3, 1, 1,   1, 2, 0, 0, 1, 0, 0, 1'b1);
    shot(4, 4, 1, 0,   0, 1, 0, 0, 0, 0, 0, 1'b1);
    shot(5, 5, 0, 1,   0, 0, 0, 0, 1, 1, 0, 1'b1);
    shot(6, 6, 0, 3,   0, 0, 0, 0, 0, 0, 0, 1'b0);
    chk("done_over", int'(GameOver), 1);
    chk("done_won", int'(Won), 0);
    chk("done_shots", int'(ShotsLeft), 0);
    chk("done_last", int'(LastResult), 1);
    chk("done_x", int'(X), 5);

    // Winning game.
    do_reset();
    shot(1, 0, 0, 3,   0, 4, 3, 1, 3, 0, 0, 1'b1);
    shot(2, 0, 0, 3,   0, 3, 3, 2, 3, 0, 0, 1'b1);
    shot(3, 0, 0, 3,   0, 2, 3, 3, 3, 1, 1, 1'b1);
    chk("win_over", int'(GameOver), 1);
    chk("win_won", int'(Won), 1);

    // Reset landing in the FIRE cycle aborts the shot.
    do_reset();
    shot(8, 8, 1, 3,   1, 4, 2, 1, 3, 0, 0, 1'b1);
    XIn = 4'd9; YIn = 4'd9; BigReq = 1'b1; Hit = 1'b1;
    FireKey = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(posedge clock);
      #1;
      if (ScoreThis === 1'b1) seen = 1;
    end
    chk("abort_strobe_seen", seen, 1);
    reset = 1'b1;
    FireKey = 1'b0;
    #1;
    chk("abort_strobe", int'(ScoreThis), 0);
    chk("abort_shots", int'(ShotsLeft), 5);
    chk("abort_big_left", int'(BigLeft), 3);
    chk("abort_hits", int'(HitCount), 0);
    chk("abort_over", int'(GameOver), 0);
    chk("abort_x", int'(X), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    Hit = 1'b0;
    repeat (20) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
